// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC readout path.
package tdc_pkg;

    localparam int TDC_WORD_W        = 16;
    localparam int TDC_DEFAULT_DEPTH = 256;

    typedef logic [TDC_WORD_W-1:0] tdc_word_t;

endpackage

// File: rtl/tdc_buffer_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The output register only loads on a read, so it holds its last word between reads.
module tdc_buffer_ram
    import tdc_pkg::*;
#(
    parameter int DEPTH = TDC_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tdc_word_t     wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output tdc_word_t     rdata
);

    tdc_word_t mem [DEPTH];

    // NOTE: no reset on the array or the read register, so synthesis can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tdc_result_buffer.sv
// Result buffer between the TDC sequencer and host readout: occupancy, overflow, 1-cycle reads.
// Optional macro TDC_BUFFER_OVERFLOW_COUNT_EN adds a saturating dropped-write counter port.
module tdc_result_buffer
    import tdc_pkg::*;
#(
    parameter  int DEPTH = TDC_DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          write,
    input  tdc_word_t     data,
    input  logic          rd_en,
    output tdc_word_t     rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
    output logic [15:0]   overflow_count,
`endif
    output logic          overflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          wr_accept;
    logic          wr_drop;
    logic          rd_accept;
    logic          has_read;
    tdc_word_t     ram_q;

    // Flags decode the registered count only, so no input reaches them combinationally.
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Acceptance uses pre-edge flags; a same-cycle read never frees a slot for the write.
    assign wr_accept = write & ~full & ~clear;
    assign wr_drop   = write &  full & ~clear;
    assign rd_accept = rd_en & ~empty & ~clear;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (wr_accept && !rd_accept) begin
            count_next = count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            has_read <= 1'b0;
        end else begin
            count    <= count_next;
            rd_valid <= rd_accept;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
                if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
                if (wr_drop)   overflow <= 1'b1;
            end
            if (rd_accept) has_read <= 1'b1;
        end
    end

`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_count <= '0;
        end else if (clear) begin
            overflow_count <= '0;
        end else if (wr_drop && overflow_count != 16'hFFFF) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end
`endif

    tdc_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (data),
        .re    (rd_accept),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // The RAM register has no reset; mask it until the first read since reset so rd_data reads 0.
    assign rd_data = has_read ? ram_q : '0;

endmodule

// File: tb/tb_tdc_result_buffer.sv
// Directed self-checking bench for tdc_result_buffer at DEPTH=16.
module tb_tdc_result_buffer;
    import tdc_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        write = 1'b0;
    tdc_word_t   data = '0;
    logic        rd_en = 1'b0;
    tdc_word_t   rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
    logic [15:0] overflow_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdc_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .write          (write),
        .data           (data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .count          (count),
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
        .overflow_count (overflow_count),
`endif
        .overflow       (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input tdc_word_t d, input logic r, input logic c);
        write = w;
        data  = d;
        rd_en = r;
        clear = c;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"},  rd_data,  0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_empty"},    empty,    1);
        check({tag, "_full"},     full,     0);
        check({tag, "_count"},    count,    0);
        check({tag, "_overflow"}, overflow, 0);
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
        check({tag, "_ovf_cnt"},  overflow_count, 0);
`endif
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Three writes then three separated reads
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0);
            tick();
            check("wr3_count", count, 32'(i));
        end
        check("wr3_empty", empty, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            check("rd3_valid", rd_valid, 1);
            check("rd3_data",  rd_data,  32'(i));
            check("rd3_count", count,    32'(3 - i));
            drive(1'b0, '0, 1'b0, 1'b0);
            tick();
            check("rd3_pulse", rd_valid, 0);
            check("rd3_hold",  rd_data,  32'(i));
        end
        check("rd3_empty", empty, 1);

        // Overflow: 18 writes into 16 slots
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
            tick();
            if (i == 15) begin
                check("ovf_full16", full, 1);
                check("ovf_noflag16", overflow, 0);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("ovf_full",  full,     1);
        check("ovf_count", count,    16);
        check("ovf_flag",  overflow, 1);
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
        check("ovf_cnt", overflow_count, 2);
`endif
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            check("drain_valid", rd_valid, 1);
            check("drain_data",  rd_data,  32'(16'h1000 + i));
        end
        check("drain_empty",  empty,    1);
        check("drain_sticky", overflow, 1);

        // rd_en held while empty
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            check("mt_valid", rd_valid, 0);
            check("mt_data",  rd_data,  16'h100F);
            check("mt_count", count,    0);
        end

        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("clr_overflow", overflow, 0);
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
        check("clr_ovf_cnt", overflow_count, 0);
`endif

        // Continuous write+read with 5 words resident
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
            tick();
        end
        check("bb_prefill", count, 5);
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 16'(16'h2005 + i), 1'b1, 1'b0);
            tick();
            check("bb_valid", rd_valid, 1);
            check("bb_data",  rd_data,  32'(16'(16'h2000 + i)));
            check("bb_count", count,    5);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            check("bb_tail", rd_data, 32'(16'(16'h23E8 + i)));
        end
        check("bb_empty", empty, 1);

        // clear beats a concurrent write and read, after an overflow
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
            tick();
        end
        check("cl_overflow_set", overflow, 1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        check("cl_count7", count, 7);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("cl_count",    count,    0);
        check("cl_empty",    empty,    1);
        check("cl_overflow", overflow, 0);
        check("cl_rd_valid", rd_valid, 0);
`ifdef TDC_BUFFER_OVERFLOW_COUNT_EN
        check("cl_ovf_cnt", overflow_count, 0);
`endif
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("cl_after_data", rd_data, 16'h1234);
        check("cl_after_cnt",  count,   0);

        // Asynchronous reset mid-stream with 9 words and a read in flight
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("mr_count9", count,    9);
        check("mr_valid",  rd_valid, 1);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mr");
        tick();
        tick();
        check_reset_values("mr_hold");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
        tick();
        check("mr_wr_count", count, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("mr_rd_valid", rd_valid, 1);
        check("mr_rd_data",  rd_data,  16'hA5A5);
        check("mr_empty",    empty,    1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
